// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the two-cache memory arbiter.
// States, owner encoding and the default bus widths live here so every block agrees.
package arbiter_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int DATA_W_DEF  = 128;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_REQ   = 3'd1,
        I_BUSY  = 3'd2,
        D_REQ   = 3'd3,
        D_BUSY  = 3'd4,
        RELEASE = 3'd5
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // True while a memory transaction is outstanding and the watchdog should run.
    function automatic logic in_transaction(input state_t s);
        return (s == I_REQ) || (s == I_BUSY) || (s == D_REQ) || (s == D_BUSY);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts enabled cycles, clears on demand, and raises a
// sticky flag once the count reaches LIMIT. Only reset clears the flag.
module arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic count,
    input  logic clear,
    output logic flag
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles <= '0;
            flag   <= 1'b0;
        end else begin
            if (clear) begin
                cycles <= '0;
            end else if (count && (cycles != CW'(LIMIT))) begin
                cycles <= cycles + 1'b1;
            end
            // The flag rises on the same edge that the count reaches LIMIT.
            if (count && !clear && (cycles == CW'(LIMIT - 1))) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one shared block memory between an instruction cache and a data cache,
// round-robin on ties, with a one-cycle RELEASE handshake back to the served cache.
module memory_arbiter
    import arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_mem_Read,
    input  logic [ADDR_W-1:0] i_mem_Address,
    output logic [DATA_W-1:0] i_mem_Readdata,
    output logic              i_mem_BusyWait,
    input  logic              d_mem_Read,
    input  logic              d_mem_Write,
    input  logic [ADDR_W-1:0] d_mem_Address,
    input  logic [DATA_W-1:0] d_mem_Writedata,
    output logic [DATA_W-1:0] d_mem_Readdata,
    output logic              d_mem_BusyWait,
    output logic              mem_Read,
    output logic              mem_Write,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_Writedata,
    input  logic [DATA_W-1:0] mem_Readdata,
    input  logic              mem_BusyWait,
    output logic              timeout_err
);

    state_t state;
    owner_t owner;
    owner_t last_grant;

    logic i_req;
    logic d_req;
    logic wd_count;
    logic wd_clear;

    assign i_req = i_mem_Read;
    assign d_req = d_mem_Read | d_mem_Write;

    // A requester is stalled at all times except the single RELEASE cycle of its own grant.
    assign i_mem_BusyWait = i_req && !((state == RELEASE) && (owner == OWN_I));
    assign d_mem_BusyWait = d_req && !((state == RELEASE) && (owner == OWN_D));

    assign wd_count = in_transaction(state);
    assign wd_clear = (state == IDLE);

    arb_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .clock(clock),
        .reset(reset),
        .count(wd_count),
        .clear(wd_clear),
        .flag (timeout_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= OWN_I;
            last_grant     <= OWN_I;
            mem_Read       <= 1'b0;
            mem_Write      <= 1'b0;
            mem_Address    <= '0;
            mem_Writedata  <= '0;
            i_mem_Readdata <= '0;
            d_mem_Readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the cache that was not served last wins.
                    if (d_req && (!i_req || (last_grant == OWN_I))) begin
                        state         <= D_REQ;
                        owner         <= OWN_D;
                        last_grant    <= OWN_D;
                        mem_Write     <= d_mem_Write;
                        mem_Read      <= !d_mem_Write;
                        mem_Address   <= d_mem_Address;
                        mem_Writedata <= d_mem_Writedata;
                    end else if (i_req) begin
                        state         <= I_REQ;
                        owner         <= OWN_I;
                        last_grant    <= OWN_I;
                        mem_Read      <= 1'b1;
                        mem_Write     <= 1'b0;
                        mem_Address   <= i_mem_Address;
                        mem_Writedata <= '0;
                    end
                end
                I_REQ: begin
                    if (mem_BusyWait) state <= I_BUSY;
                end
                D_REQ: begin
                    if (mem_BusyWait) state <= D_BUSY;
                end
                I_BUSY, D_BUSY: begin
                    if (!mem_BusyWait) begin
                        // A requester that withdrew mid-transaction gets nothing back.
                        if ((state == I_BUSY) && i_req) i_mem_Readdata <= mem_Readdata;
                        if ((state == D_BUSY) && d_req) d_mem_Readdata <= mem_Readdata;
                        mem_Read      <= 1'b0;
                        mem_Write     <= 1'b0;
                        mem_Address   <= '0;
                        mem_Writedata <= '0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized scoreboard bench for memory_arbiter: a reference model predicts grant
// order, memory commands and returned blocks; monitors compare as the DUT responds.
module tb_memory_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          clock;
  logic          reset;
  logic          i_mem_Read;
  logic [AW-1:0] i_mem_Address;
  logic [DW-1:0] i_mem_Readdata;
  logic          i_mem_BusyWait;
  logic          d_mem_Read;
  logic          d_mem_Write;
  logic [AW-1:0] d_mem_Address;
  logic [DW-1:0] d_mem_Writedata;
  logic [DW-1:0] d_mem_Readdata;
  logic          d_mem_BusyWait;
  logic          mem_Read;
  logic          mem_Write;
  logic [AW-1:0] mem_Address;
  logic [DW-1:0] mem_Writedata;
  logic [DW-1:0] mem_Readdata;
  logic          mem_BusyWait;
  logic          timeout_err;

  memory_arbiter dut (
    .clock(clock),
    .reset(reset),
    .i_mem_Read(i_mem_Read),
    .i_mem_Address(i_mem_Address),
    .i_mem_Readdata(i_mem_Readdata),
    .i_mem_BusyWait(i_mem_BusyWait),
    .d_mem_Read(d_mem_Read),
    .d_mem_Write(d_mem_Write),
    .d_mem_Address(d_mem_Address),
    .d_mem_Writedata(d_mem_Writedata),
    .d_mem_Readdata(d_mem_Readdata),
    .d_mem_BusyWait(d_mem_BusyWait),
    .mem_Read(mem_Read),
    .mem_Write(mem_Write),
    .mem_Address(mem_Address),
    .mem_Writedata(mem_Writedata),
    .mem_Readdata(mem_Readdata),
    .mem_BusyWait(mem_BusyWait),
    .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "global cycle budget exhausted");
  end

  // ---------------- scoreboard state ----------------
  int   n_vec = 0;
  int   n_err = 0;
  int   force_lat = -1;
  logic model_last = 1'b0;  // 0: instruction cache was granted last
  cmd_t          mem_exp_q[$];
  logic [DW-1:0] i_exp_q[$];
  cmd_t          d_exp_q[$];
  logic [DW-1:0] wr_map[logic [AW-1:0]];
  logic [DW-1:0] mem_store[logic [AW-1:0]];

  task automatic check(input string name, input logic [DW+31:0] act, input logic [DW+31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  function automatic logic [DW-1:0] expect_data(input logic [AW-1:0] a);
    if (wr_map.exists(a)) return wr_map[a];
    return pattern(a);
  endfunction

  // Reference model: record one granted transaction in service order.
  task automatic push_i(input logic [AW-1:0] a);
    cmd_t c;
    c.wr = 1'b0; c.addr = a; c.data = '0;
    mem_exp_q.push_back(c);
    i_exp_q.push_back(expect_data(a));
    model_last = 1'b0;
  endtask

  task automatic push_d(input cmd_t c);
    cmd_t r;
    mem_exp_q.push_back(c);
    if (c.wr) wr_map[c.addr] = c.data;
    r = c;
    if (!c.wr) r.data = expect_data(c.addr);
    d_exp_q.push_back(r);
    model_last = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic i_read(input logic [AW-1:0] a);
    int n = 0;
    i_mem_Read = 1'b1;
    i_mem_Address = a;
    do begin @(negedge clock); n++; end while (i_mem_BusyWait && n < 800);
    check("i_handshake", i_mem_BusyWait, 0);
    @(posedge clock); #1;
    i_mem_Read = 1'b0;
  endtask

  task automatic d_op(input cmd_t c, input logic both);
    int n = 0;
    d_mem_Write = c.wr;
    d_mem_Read = !c.wr || both;
    d_mem_Address = c.addr;
    d_mem_Writedata = c.wr ? c.data : {$urandom, $urandom, $urandom, $urandom};
    do begin @(negedge clock); n++; end while (d_mem_BusyWait && n < 800);
    check("d_handshake", d_mem_BusyWait, 0);
    @(posedge clock); #1;
    d_mem_Read = 1'b0;
    d_mem_Write = 1'b0;
  endtask

  // Both caches request back-to-back; the model derives service order from round-robin.
  task automatic run_both(input int ni, input int nd);
    logic [AW-1:0] iq[$];
    cmd_t dq[$];
    logic db[$];
    cmd_t c;
    int ii = 0;
    int di = 0;
    for (int k = 0; k < ni; k++) iq.push_back({16'h0, 4'h1, 8'($urandom_range(0, 255))});
    for (int k = 0; k < nd; k++) begin
      c.wr = 1'($urandom_range(0, 1));
      c.addr = {16'h0, (c.wr ? 4'h8 : 4'h4), 8'($urandom_range(0, 255))};
      c.data = c.wr ? {$urandom, $urandom, $urandom, $urandom} : '0;
      dq.push_back(c);
      db.push_back(c.wr && ($urandom_range(0, 1) == 1));
    end
    while (ii < ni || di < nd) begin
      if (di < nd && (ii >= ni || model_last == 1'b0)) begin
        push_d(dq[di]); di++;
      end else begin
        push_i(iq[ii]); ii++;
      end
    end
    @(posedge clock); #1;
    fork
      begin foreach (iq[k]) i_read(iq[k]); end
      begin foreach (dq[k]) d_op(dq[k], db[k]); end
    join
  endtask

  // ---------------- memory responder / command monitor ----------------
  initial begin
    cmd_t          e;
    logic          cur_r, cur_w, serving, rel_chk, hold_ok;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;
    int            lat;
    serving = 0; rel_chk = 0; hold_ok = 1; lat = 0;
    cur_r = 0; cur_w = 0; cur_a = '0; cur_d = '0;
    mem_BusyWait = 1'b0;
    mem_Readdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        serving = 0; rel_chk = 0; mem_BusyWait = 1'b0;
      end else if (rel_chk) begin
        rel_chk = 0;
        check("release_cmd_idle", {mem_Read, mem_Write, mem_Address}, 0);
        check("release_pulse", 32'((i_mem_Read && !i_mem_BusyWait))
              + 32'(((d_mem_Read || d_mem_Write) && !d_mem_BusyWait)), 1);
      end else if (!serving) begin
        if (mem_Read || mem_Write) begin
          if (mem_exp_q.size() == 0) begin
            check("unexpected_cmd", {mem_Read, mem_Write, mem_Address}, 0);
          end else begin
            e = mem_exp_q.pop_front();
            check("cmd_kind", {mem_Read, mem_Write}, {!e.wr, e.wr});
            check("cmd_addr", mem_Address, e.addr);
            if (e.wr) check("cmd_wdata", mem_Writedata, e.data);
          end
          cur_r = mem_Read; cur_w = mem_Write; cur_a = mem_Address; cur_d = mem_Writedata;
          hold_ok = 1; serving = 1;
          mem_BusyWait = 1'b1;
          lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 5);
        end
      end else begin
        if (mem_Read !== cur_r || mem_Write !== cur_w || mem_Address !== cur_a
            || (cur_w && mem_Writedata !== cur_d)) hold_ok = 0;
        if (lat == 0) begin
          check("cmd_hold", hold_ok, 1);
          if (cur_w) begin
            mem_store[cur_a] = cur_d;
            mem_Readdata = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            mem_Readdata = mem_store.exists(cur_a) ? mem_store[cur_a] : pattern(cur_a);
          end
          mem_BusyWait = 1'b0;
          serving = 0;
          rel_chk = 1;
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- requester response monitor ----------------
  initial begin
    cmd_t e;
    logic [DW-1:0] x;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (i_mem_Read && !i_mem_BusyWait) begin
          if (i_exp_q.size() == 0) check("unexpected_i_resp", 1, 0);
          else begin
            x = i_exp_q.pop_front();
            check("i_readdata", i_mem_Readdata, x);
          end
        end
        if ((d_mem_Read || d_mem_Write) && !d_mem_BusyWait) begin
          if (d_exp_q.size() == 0) check("unexpected_d_resp", 1, 0);
          else begin
            e = d_exp_q.pop_front();
            if (!e.wr) check("d_readdata", d_mem_Readdata, e.data);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    cmd_t w;
    reset = 1'b1;
    i_mem_Read = 1'b0; i_mem_Address = '0;
    d_mem_Read = 1'b0; d_mem_Write = 1'b0; d_mem_Address = '0; d_mem_Writedata = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_mem_cmd", {mem_Read, mem_Write}, 0);
    check("rst_mem_addr", mem_Address, 0);
    check("rst_mem_wdata", mem_Writedata, 0);
    check("rst_i_readdata", i_mem_Readdata, 0);
    check("rst_d_readdata", d_mem_Readdata, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_busywait", {i_mem_BusyWait, d_mem_BusyWait}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Simultaneous requests right after reset: data cache first, then alternate.
    run_both(4, 4);

    // Single instruction read with a 4-cycle busy memory and grant latency.
    force_lat = 4;
    push_i(28'h0000010);
    @(posedge clock); #1;
    fork
      i_read(28'h0000010);
      begin
        @(negedge clock);
        check("pre_grant_read", mem_Read, 0);
        @(negedge clock);
        check("grant_latency_read", mem_Read, 1);
        check("grant_addr", mem_Address, 28'h0000010);
      end
    join
    force_lat = -1;
    repeat (3) @(negedge clock);
    check("i_readdata_hold", i_mem_Readdata, pattern(28'h0000010));
    run_both(5, 0);

    // Write-back with Read and Write both set; then read the block back from both sides.
    w.wr = 1'b1; w.addr = 28'h0000020; w.data = {4{32'hDEADBEEF}};
    push_d(w);
    @(posedge clock); #1;
    d_op(w, 1'b1);
    w.wr = 1'b0; w.data = '0;
    push_d(w);
    d_op(w, 1'b0);
    push_i(28'h0000020);
    i_read(28'h0000020);
    w.addr = 28'h0000400;
    push_d(w);
    d_op(w, 1'b0);
    check("i_hold_across_d", i_mem_Readdata, {4{32'hDEADBEEF}});

    // Randomized contention rounds.
    for (int r = 0; r < 4; r++) run_both($urandom_range(1, 5), $urandom_range(1, 5));

    // Memory stuck busy: watchdog trips during the transaction and stays set.
    force_lat = 300;
    push_i(28'h0000150);
    @(posedge clock); #1;
    fork
      i_read(28'h0000150);
      begin
        for (int n = 0; n < 10 && !mem_Read; n++) @(negedge clock);
        check("stuck_grant", mem_Read, 1);
        repeat (245) @(negedge clock);
        check("timeout_not_early", timeout_err, 0);
        repeat (20) @(negedge clock);
        check("timeout_set", timeout_err, 1);
      end
    join
    force_lat = -1;
    check("timeout_after_done", timeout_err, 1);
    run_both(1, 1);
    check("timeout_sticky", timeout_err, 1);
    @(posedge clock); #1; reset = 1'b1;
    repeat (2) @(posedge clock); #1; reset = 1'b0;
    model_last = 1'b0;
    @(negedge clock);
    check("timeout_cleared", timeout_err, 0);

    // Reset while the instruction cache transaction is in progress.
    force_lat = 20;
    w.wr = 1'b0; w.addr = 28'h0000166; w.data = '0;
    mem_exp_q.push_back(w);
    @(posedge clock); #1;
    i_mem_Read = 1'b1; i_mem_Address = 28'h0000166;
    repeat (4) @(negedge clock);
    check("busy_before_reset", {mem_Read, i_mem_BusyWait}, 2'b11);
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    check("stall_at_reset", i_mem_BusyWait, 1);
    @(negedge clock);
    check("reset_mem_idle", {mem_Read, mem_Write, mem_Address, mem_Writedata}, 0);
    check("reset_no_pulse", i_mem_BusyWait, 1);
    check("reset_readdata", i_mem_Readdata, 0);
    @(posedge clock); #1;
    i_mem_Read = 1'b0; reset = 1'b0;
    model_last = 1'b0;
    force_lat = -1;
    repeat (3) @(negedge clock);
    check("idle_after_reset", {mem_Read, mem_Write}, 0);

    // Recovery: round-robin restarts with the data cache.
    run_both(2, 2);

    repeat (3) @(negedge clock);
    check("mem_q_drained", mem_exp_q.size(), 0);
    check("i_q_drained", i_exp_q.size(), 0);
    check("d_q_drained", d_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, 28, block address width (word address bits [31:4]).
REQ-002 Parameter DATA_W, 128, block data width (4 instruction/data words).
REQ-003 Parameter TIMEOUT, 255, watchdog limit in cycles for one memory transaction.
REQ-004 Ports SHALL be:
  - clock  in  1  sole clock, all state on rising edge.
  - reset  in  1  synchronous, active-high.
  - i_mem_Read  in  1  instruction-cache block read request.
  - i_mem_Address  in  ADDR_W  instruction-cache block address.
  - i_mem_Readdata  out  DATA_W  block returned to instruction cache.
  - i_mem_BusyWait  out  1  stall to instruction cache.
  - d_mem_Read  in  1  data-cache block read request.
  - d_mem_Write  in  1  data-cache block write-back request.
  - d_mem_Address  in  ADDR_W  data-cache block address.
  - d_mem_Writedata  in  DATA_W  data-cache write-back block.
  - d_mem_Readdata  out  DATA_W  block returned to data cache.
  - d_mem_BusyWait  out  1  stall to data cache.
  - mem_Read  out  1  read command to shared memory.
  - mem_Write  out  1  write command to shared memory.
  - mem_Address  out  ADDR_W  shared memory address.
  - mem_Writedata  out  DATA_W  shared memory write data.
  - mem_Readdata  in  DATA_W  shared memory read data.
  - mem_BusyWait  in  1  memory busy; falling edge marks completion.
  - timeout_err  out  1  sticky watchdog error flag.

Function
REQ-005 States SHALL be IDLE, I_REQ, I_BUSY, D_REQ, D_BUSY, RELEASE; owner register records I or D.
REQ-006 IDLE: one request -> grant it; both -> grant the non-last-granted owner (round-robin); none -> stay.
REQ-007 Data request SHALL mean d_mem_Read OR d_mem_Write; both set -> Write takes precedence.
REQ-008 x_REQ: drive mem_Read/mem_Write, mem_Address, mem_Writedata from the registered owner's command; move to x_BUSY on the first cycle mem_BusyWait=1.
REQ-009 x_BUSY: hold command; when mem_BusyWait=0, register mem_Readdata into x_mem_Readdata, drop mem command, go RELEASE.
REQ-010 RELEASE: x_mem_BusyWait=0 for exactly this one cycle, then IDLE; the other requester stays stalled.
REQ-011 x_mem_BusyWait SHALL be 1 whenever x requests and is not in its RELEASE cycle; 0 when x is not requesting.
REQ-012 Command latched at grant SHALL be held until completion even if requester withdraws; result is discarded.
REQ-013 Memory command outputs SHALL be 0 in IDLE and RELEASE; no back-to-back grant without the RELEASE cycle.
REQ-014 Latency: request in IDLE -> mem command next cycle; requester sees BusyWait=0 one cycle after memory completion.
REQ-015 Watchdog counter SHALL count cycles in x_REQ/x_BUSY, clear on IDLE; reaching TIMEOUT sets timeout_err (sticky), transaction continues.
REQ-016 Readdata output registers SHALL hold last returned block until next completion for that owner.

Reset
REQ-017 Reset SHALL force IDLE, last-granted=I (data cache wins first tie), all mem outputs 0, both Readdata 0, counter 0, timeout_err 0.
REQ-018 Reset mid-transaction SHALL abandon it at the next edge; no RELEASE pulse is generated.

Structure
REQ-019 State encoding, owner encoding, ADDR_W/DATA_W defaults SHALL live in shared package arbiter_pkg.
REQ-020 Watchdog SHALL be sub-module arb_watchdog (count, clear, limit -> sticky flag).

Verification
REQ-021 Single I read 0x0000010, memory busy 4 cycles -> mem_Read 1 cycle after request, i_mem_Readdata valid, i_mem_BusyWait=0 one cycle.
REQ-022 I and D read same cycle after reset -> D served first, then I; no overlap of mem commands.
REQ-023 Both request continuously for 4 transactions -> grants alternate D,I,D,I.
REQ-024 d_mem_Write with Writedata 0xDEADBEEF... at 0x0000020 -> mem_Write, matching address/data held until mem_BusyWait falls.
REQ-025 mem_BusyWait stuck high 300 cycles -> timeout_err=1 at cycle 255, stays 1 until reset.
REQ-026 Reset asserted in I_BUSY -> next edge IDLE, all mem outputs 0, no BusyWait=0 pulse to I.
